// File: rtl/hls_ctrl_pkg.sv
// Shared definitions for the ap_ctrl_hs initiator and the future ap_ctrl_chain variant.
package hls_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERR       = 3'd4
  } ctrl_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 32'd1048576;

  // Bit positions of the ap_ctrl signals in the HLS control/status register word.
  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;
  localparam int AP_READY_BIT = 3;

  function automatic logic [3:0] ap_status_word(input logic start, input logic done,
                                                input logic idle, input logic ready);
    logic [3:0] w;
    w               = '0;
    w[AP_START_BIT] = start;
    w[AP_DONE_BIT]  = done;
    w[AP_IDLE_BIT]  = idle;
    w[AP_READY_BIT] = ready;
    return w;
  endfunction

endpackage

// File: rtl/hls_ap_ctrl_master_if.sv
// ap_ctrl_hs block-level handshake between the controller (master) and one kernel (slave).
interface hls_ap_ctrl_master_if;
  logic ap_start;
  logic ap_idle;
  logic ap_ready;
  logic ap_done;

  modport master (output ap_start, input ap_idle, input ap_ready, input ap_done);
  modport slave  (input ap_start, output ap_idle, output ap_ready, output ap_done);
endinterface

// File: rtl/hls_run_timer.sv
// Per-invocation cycle counter: saturating count, watchdog compare and latency latch.
module hls_run_timer #(
  parameter int          CYC_W   = 32,
  parameter int unsigned TIMEOUT = 32'd1048576
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             run,
  input  logic             latch,
  output logic             expired,
  output logic [CYC_W-1:0] last_cycles
);

  localparam logic [CYC_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] LIMIT   = CYC_W'(TIMEOUT);

  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] cnt_incl;

  // cnt_incl is the run length including the current cycle; a run may last
  // exactly LIMIT cycles, so a done in that cycle still wins over the watchdog.
  assign cnt_incl = (cnt == CNT_MAX) ? CNT_MAX : cnt + CYC_W'(1);
  assign expired  = run && (cnt_incl >= LIMIT);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt         <= '0;
      last_cycles <= '0;
    end else begin
      if (!run) cnt <= '0;
      else      cnt <= cnt_incl;
      if (latch) last_cycles <= cnt_incl;
    end
  end

endmodule

// File: rtl/hls_ap_ctrl_master.sv
// Initiator for ap_ctrl_hs kernels: runs a kernel N times with latency tracking and a watchdog.
//
//   state     | meaning
//   IDLE      | ready for a host command
//   WAIT_IDLE | waiting for the kernel to report ap_idle
//   START     | ap_start held high until ap_ready
//   RUN       | kernel accepted the start, waiting for ap_done
//   ERR       | watchdog expired, one cycle before returning to IDLE
module hls_ap_ctrl_master
  import hls_ctrl_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter int          CYC_W   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic                 cmd_abort,
  hls_ap_ctrl_master_if.master ap,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     runs_done,
  output logic [CYC_W-1:0]     last_cycles
);

  ctrl_state_e      state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             load;
  logic             run_done;
  logic             timeout_hit;
  logic             done_nxt;
  logic             timer_run;
  logic             expired;

  // All status outputs decode directly from registers.
  assign cmd_ready   = (state == ST_IDLE);
  assign ap.ap_start = (state == ST_START);
  assign busy        = (state == ST_WAIT_IDLE) || (state == ST_START) || (state == ST_RUN);
  assign timer_run   = (state == ST_START) || (state == ST_RUN);

  hls_run_timer #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .run         (timer_run),
    .latch       (run_done),
    .expired     (expired),
    .last_cycles (last_cycles)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    run_done    = 1'b0;
    timeout_hit = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          load = 1'b1;
          if (cmd_count == '0) done_nxt  = 1'b1;
          else                 state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (ap.ap_idle) state_nxt = ST_START;
      end
      ST_START, ST_RUN: begin
        if (ap.ap_done) begin
          run_done = 1'b1;
          if ((remaining == CNT_W'(1)) || cmd_abort) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAIT_IDLE;
          end
        end else if (expired) begin
          state_nxt   = ST_ERR;
          timeout_hit = 1'b1;
          done_nxt    = 1'b1;
        end else if ((state == ST_START) && ap.ap_ready) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      remaining   <= '0;
      runs_done   <= '0;
      timeout_err <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      done_pulse <= done_nxt;
      if (load) begin
        remaining   <= cmd_count;
        runs_done   <= '0;
        timeout_err <= 1'b0;
      end else if (run_done) begin
        remaining <= remaining - CNT_W'(1);
        runs_done <= runs_done + CNT_W'(1);
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hls_ap_ctrl_master.sv
// Directed bench for hls_ap_ctrl_master with a small ap_ctrl_hs kernel model.
module tb_hls_ap_ctrl_master;

  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_abort = 1'b0;
  logic             busy;
  logic             done_pulse;
  logic             timeout_err;
  logic [CNT_W-1:0] runs_done;
  logic [CYC_W-1:0] last_cycles;

  hls_ap_ctrl_master_if ap_if ();

  hls_ap_ctrl_master #(
    .CNT_W   (CNT_W),
    .CYC_W   (CYC_W),
    .TIMEOUT (64)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_count   (cmd_count),
    .cmd_abort   (cmd_abort),
    .ap          (ap_if),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .timeout_err (timeout_err),
    .runs_done   (runs_done),
    .last_cycles (last_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // Kernel model: idx 0 is the first cycle ap_start is seen high.
  int kern_active = 0;
  int kern_idx = 0;
  int rdy_off = 1000;
  int done_off = 1000;
  int windows = 0;
  int pulses = 0;
  int viol = 0;

  initial begin
    ap_if.ap_idle  = 1'b1;
    ap_if.ap_ready = 1'b0;
    ap_if.ap_done  = 1'b0;
  end

  always @(posedge ap_clk) begin
    #1;
    if (kern_active != 0 && kern_idx == done_off) kern_active = 0;
    if (kern_active == 0 && ap_if.ap_start) begin
      kern_active = 1;
      kern_idx    = 0;
      windows++;
    end else if (kern_active != 0) begin
      kern_idx++;
    end
    if (kern_active != 0) begin
      if (kern_idx <= rdy_off && kern_idx <= done_off && !ap_if.ap_start) viol++;
      if (rdy_off < done_off && kern_idx == rdy_off + 1 && ap_if.ap_start) viol++;
    end
    if (done_pulse) pulses++;
    ap_if.ap_ready = (kern_active != 0) && (kern_idx == rdy_off);
    ap_if.ap_done  = (kern_active != 0) && (kern_idx == done_off);
    ap_if.ap_idle  = (kern_active == 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a command for one edge; returns at the negedge of cycle T+1.
  task automatic issue(input int count);
    cmd_count = CNT_W'(count);
    cmd_valid = 1'b1;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n;
    n = 0;
    while (!done_pulse && n < budget) begin
      @(negedge ap_clk);
      n++;
    end
    chk(tag, {63'd0, done_pulse}, 64'd1);
  endtask

  task automatic kern_setup(input int rdy, input int dn);
    rdy_off     = rdy;
    done_off    = dn;
    kern_active = 0;
    windows     = 0;
    pulses      = 0;
    viol        = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    #1;
    chk("rst_ap_start", {63'd0, ap_if.ap_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done_pulse", {63'd0, done_pulse}, 64'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_runs_done", 64'(runs_done), 64'd0);
    chk("rst_last_cycles", 64'(last_cycles), 64'd0);
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);

    // Basic: ready+done 10 cycles after ap_start rises.
    kern_setup(10, 10);
    issue(1);
    chk("basic_busy_t1", {63'd0, busy}, 64'd1);
    chk("basic_cmd_ready_t1", {63'd0, cmd_ready}, 64'd0);
    @(negedge ap_clk);
    chk("basic_start_t2", {63'd0, ap_if.ap_start}, 64'd1);
    repeat (10) @(negedge ap_clk);
    chk("basic_start_done_cycle", {63'd0, ap_if.ap_start}, 64'd1);
    chk("basic_no_early_pulse", {63'd0, done_pulse}, 64'd0);
    @(negedge ap_clk);
    chk("basic_done_pulse", {63'd0, done_pulse}, 64'd1);
    chk("basic_busy_low", {63'd0, busy}, 64'd0);
    chk("basic_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("basic_runs_done", 64'(runs_done), 64'd1);
    chk("basic_last_cycles", 64'(last_cycles), 64'd11);
    @(negedge ap_clk);
    chk("basic_pulse_single", 64'(pulses), 64'd1);
    chk("basic_windows", 64'(windows), 64'd1);

    // Three runs: ready at +2, done at +20.
    kern_setup(2, 20);
    issue(3);
    wait_pulse("three_pulse", 120);
    chk("three_runs_done", 64'(runs_done), 64'd3);
    chk("three_last_cycles", 64'(last_cycles), 64'd21);
    chk("three_windows", 64'(windows), 64'd3);
    chk("three_start_drop", 64'(viol), 64'd0);
    @(negedge ap_clk);
    chk("three_pulse_single", 64'(pulses), 64'd1);

    // Zero count: immediate completion, no ap_start.
    kern_setup(3, 3);
    issue(0);
    chk("zero_done_pulse", {63'd0, done_pulse}, 64'd1);
    chk("zero_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("zero_runs_done", 64'(runs_done), 64'd0);
    repeat (4) @(negedge ap_clk);
    chk("zero_windows", 64'(windows), 64'd0);
    chk("zero_pulse_single", 64'(pulses), 64'd1);

    // Abort raised during run 2 of 5.
    kern_setup(10, 10);
    issue(5);
    n = 0;
    while (windows < 2 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk("abort_reached_run2", 64'(windows), 64'd2);
    cmd_abort = 1'b1;
    wait_pulse("abort_pulse", 60);
    chk("abort_runs_done", 64'(runs_done), 64'd2);
    chk("abort_last_cycles", 64'(last_cycles), 64'd11);
    repeat (5) @(negedge ap_clk);
    cmd_abort = 1'b0;
    chk("abort_windows", 64'(windows), 64'd2);
    chk("abort_pulse_single", 64'(pulses), 64'd1);

    // Timeout: kernel never answers; watchdog of 64 cycles.
    kern_setup(1000, 1000);
    issue(1);
    @(negedge ap_clk);
    chk("to_start_idx0", {63'd0, ap_if.ap_start}, 64'd1);
    repeat (63) @(negedge ap_clk);
    chk("to_start_idx63", {63'd0, ap_if.ap_start}, 64'd1);
    chk("to_err_idx63", {63'd0, timeout_err}, 64'd0);
    @(negedge ap_clk);
    chk("to_start_idx64", {63'd0, ap_if.ap_start}, 64'd0);
    chk("to_err_idx64", {63'd0, timeout_err}, 64'd1);
    chk("to_pulse_idx64", {63'd0, done_pulse}, 64'd1);
    chk("to_busy_idx64", {63'd0, busy}, 64'd0);
    @(negedge ap_clk);
    chk("to_cmd_ready_idx65", {63'd0, cmd_ready}, 64'd1);
    chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
    chk("to_runs_done", 64'(runs_done), 64'd0);
    kern_setup(3, 3);
    @(negedge ap_clk);
    issue(1);
    chk("to_err_cleared", {63'd0, timeout_err}, 64'd0);
    wait_pulse("to_recover_pulse", 40);
    chk("to_recover_runs", 64'(runs_done), 64'd1);
    chk("to_recover_cycles", 64'(last_cycles), 64'd4);

    // Asynchronous reset while in START.
    kern_setup(1000, 1000);
    @(negedge ap_clk);
    issue(2);
    @(negedge ap_clk);
    chk("ar_start_before", {63'd0, ap_if.ap_start}, 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("ar_start_async", {63'd0, ap_if.ap_start}, 64'd0);
    chk("ar_busy_async", {63'd0, busy}, 64'd0);
    chk("ar_pulse_async", {63'd0, done_pulse}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    kern_setup(1000, 1000);
    @(negedge ap_clk);
    chk("ar_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("ar_busy_after", {63'd0, busy}, 64'd0);
    chk("ar_start_after", {63'd0, ap_if.ap_start}, 64'd0);
    chk("ar_runs_done", 64'(runs_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
